// File: rtl/cpu_run_ctrl_pkg.sv
// Shared definitions for the CPU run-control block: run-state encoding and
// the default debounce interval for a board-speed system clock.
package run_ctrl_pkg;

    typedef enum logic [1:0] {
        PAUSE = 2'd0,
        RUN   = 2'd1,
        STEP  = 2'd2,
        HALT  = 2'd3
    } run_state_t;

    localparam int DEB_CYCLES_DEFAULT = 1_000_000;
    localparam int DEB_W_DEFAULT      = 20;

endpackage

// File: rtl/cpu_run_ctrl_debounce.sv
// Two-flop synchronizer plus stability-counter debouncer for one raw board
// input; provides the clean level and a one-cycle pulse on its rising edge.
module debounce #(
    parameter int DEB_CYCLES = 4,
    parameter int DEB_W      = 3
) (
    input  logic clk,
    input  logic rst_n,
    input  logic raw,
    output logic level,
    output logic rise
);

    logic             sync_a;
    logic             sync_b;
    logic [DEB_W-1:0] cnt;
    logic             settled;

    // The mismatch on the current edge is the DEB_CYCLES-th in a row.
    assign settled = (cnt == DEB_W'(DEB_CYCLES - 1));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync_a <= 1'b0;
            sync_b <= 1'b0;
            cnt    <= '0;
            level  <= 1'b0;
            rise   <= 1'b0;
        end else begin
            sync_a <= raw;
            sync_b <= sync_a;
            rise   <= 1'b0;
            if (sync_b != level) begin
                if (settled) begin
                    level <= sync_b;
                    rise  <= sync_b;
                    cnt   <= '0;
                end else begin
                    cnt <= cnt + 1'b1;
                end
            end else begin
                cnt <= '0;
            end
        end
    end

endmodule

// File: rtl/cpu_run_ctrl.sv
// Run control for the MIPS core: turns the divider tick, run switch and step
// button into a one-cycle CPU enable, tracks run state and counts steps.
module cpu_run_ctrl
    import run_ctrl_pkg::*;
#(
    parameter int DEB_CYCLES = DEB_CYCLES_DEFAULT,
    parameter int DEB_W      = DEB_W_DEFAULT,
    parameter int CNT_W      = 32
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             tick,
    input  logic             sw_run,
    input  logic             btn_step,
    input  logic             halt_req,
    output logic             cpu_en,
    output logic [1:0]       state,
    output logic [CNT_W-1:0] inst_cnt
);

    logic       run_lvl;
    logic       run_rise;
    logic       step_lvl;
    logic       step_rise;
    logic       tick_q;
    logic       tick_rise;
    logic       en_ok;
    run_state_t state_q;
    run_state_t state_n;

    debounce #(
        .DEB_CYCLES (DEB_CYCLES),
        .DEB_W      (DEB_W)
    ) u_deb_run (
        .clk   (clk),
        .rst_n (rst_n),
        .raw   (sw_run),
        .level (run_lvl),
        .rise  (run_rise)
    );

    debounce #(
        .DEB_CYCLES (DEB_CYCLES),
        .DEB_W      (DEB_W)
    ) u_deb_step (
        .clk   (clk),
        .rst_n (rst_n),
        .raw   (btn_step),
        .level (step_lvl),
        .rise  (step_rise)
    );

    assign tick_rise = tick & ~tick_q;

    // Halt takes priority everywhere; a step press outside PAUSE is dropped.
    always_comb begin
        state_n = state_q;
        if (halt_req) begin
            state_n = HALT;
        end else begin
            unique case (state_q)
                PAUSE: begin
                    if (run_lvl)        state_n = RUN;
                    else if (step_rise) state_n = STEP;
                end
                RUN: begin
                    if (!run_lvl) state_n = PAUSE;
                end
                STEP: begin
                    if (tick_rise)    state_n = PAUSE;
                    else if (run_lvl) state_n = RUN;
                end
                HALT: state_n = HALT;
                default: state_n = PAUSE;
            endcase
        end
    end

    // A tick that lands together with halt_req must not advance the core.
    assign en_ok = tick_rise & ~halt_req & ((state_q == RUN) || (state_q == STEP));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            tick_q   <= 1'b0;
            state_q  <= PAUSE;
            cpu_en   <= 1'b0;
            inst_cnt <= '0;
        end else begin
            tick_q  <= tick;
            state_q <= state_n;
            cpu_en  <= en_ok;
            if (cpu_en) begin
                inst_cnt <= inst_cnt + CNT_W'(1);
            end
        end
    end

    assign state = state_q;

endmodule

// File: tb/tb_cpu_run_ctrl.sv
// Directed bench for cpu_run_ctrl with a short debounce window and 8-bit counter.
module tb_cpu_run_ctrl;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       tick = 1'b0;
    logic       sw_run = 1'b0;
    logic       btn_step = 1'b0;
    logic       halt_req = 1'b0;
    logic       cpu_en;
    logic [1:0] state;
    logic [7:0] inst_cnt;

    int n_total = 0;
    int n_bad   = 0;

    localparam logic [1:0] S_PAUSE = 2'd0;
    localparam logic [1:0] S_RUN   = 2'd1;
    localparam logic [1:0] S_STEP  = 2'd2;
    localparam logic [1:0] S_HALT  = 2'd3;

    cpu_run_ctrl #(
        .DEB_CYCLES (4),
        .DEB_W      (3),
        .CNT_W      (8)
    ) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .tick     (tick),
        .sw_run   (sw_run),
        .btn_step (btn_step),
        .halt_req (halt_req),
        .cpu_en   (cpu_en),
        .state    (state),
        .inst_cnt (inst_cnt)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_total++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) cyc();
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        idle(2);
        rst_n = 1'b1;
        cyc();
    endtask

    // One-cycle tick, then watch cpu_en for six cycles.
    task automatic tick_pulse(output int pulses, output int first_at);
        pulses   = 0;
        first_at = 0;
        tick = 1'b1;
        for (int i = 1; i <= 6; i++) begin
            cyc();
            if (cpu_en) begin
                pulses++;
                if (first_at == 0) first_at = i;
            end
            if (i == 1) tick = 1'b0;
        end
    endtask

    int p;
    int f;
    int sum;

    initial begin
        // reset state
        idle(1);
        chk("rst_state", state, S_PAUSE);
        chk("rst_en", cpu_en, 0);
        chk("rst_cnt", inst_cnt, 0);
        rst_n = 1'b1;
        cyc();

        // ticks while paused
        sum = 0;
        for (int k = 0; k < 3; k++) begin
            tick_pulse(p, f);
            sum += p;
            idle(4);
        end
        chk("pause_pulses", sum, 0);
        chk("pause_state", state, S_PAUSE);
        chk("pause_cnt", inst_cnt, 0);

        // bounce glitches alone do not step
        btn_step = 1; cyc(); btn_step = 0; cyc();
        btn_step = 1; cyc(); btn_step = 0; cyc();
        idle(6);
        chk("glitch_state", state, S_PAUSE);

        // settled press enters STEP, one tick executes one instruction
        btn_step = 1'b1;
        idle(6);
        btn_step = 1'b0;
        idle(2);
        chk("step_state", state, S_STEP);
        tick_pulse(p, f);
        chk("step_pulses", p, 1);
        chk("step_latency", f, 1);
        chk("step_back_pause", state, S_PAUSE);
        chk("step_cnt", inst_cnt, 1);
        idle(8);

        // free run, five ticks
        do_reset();
        sw_run = 1'b1;
        idle(8);
        chk("run_state", state, S_RUN);
        sum = 0;
        for (int k = 0; k < 5; k++) begin
            tick_pulse(p, f);
            sum += p;
            idle(4);
        end
        chk("run_pulses", sum, 5);
        chk("run_cnt", inst_cnt, 5);

        // tick held high gives one enable
        sum = 0;
        tick = 1'b1;
        for (int i = 1; i <= 8; i++) begin
            cyc();
            if (cpu_en) sum++;
            if (i == 4) tick = 1'b0;
        end
        chk("held_tick_pulses", sum, 1);
        chk("held_tick_cnt", inst_cnt, 6);

        // switch off: debounced after the window, then no more enables
        sw_run = 1'b0;
        idle(3);
        chk("run_off_early", state, S_RUN);
        idle(5);
        chk("run_off_state", state, S_PAUSE);
        tick_pulse(p, f);
        chk("run_off_pulses", p, 0);
        chk("run_off_cnt", inst_cnt, 6);

        // halt coinciding with a tick edge
        sw_run = 1'b1;
        idle(8);
        chk("prehalt_state", state, S_RUN);
        tick = 1'b1;
        halt_req = 1'b1;
        cyc();
        tick = 1'b0;
        halt_req = 1'b0;
        chk("halt_en", cpu_en, 0);
        chk("halt_state", state, S_HALT);
        sum = 0;
        for (int i = 0; i < 5; i++) begin
            cyc();
            if (cpu_en) sum++;
        end
        for (int k = 0; k < 2; k++) begin
            tick_pulse(p, f);
            sum += p;
        end
        sw_run = 1'b0; idle(8);
        chk("halt_sw_off", state, S_HALT);
        btn_step = 1'b1; idle(8); btn_step = 1'b0;
        tick_pulse(p, f);
        sum += p;
        sw_run = 1'b1; idle(8);
        tick_pulse(p, f);
        sum += p;
        chk("halt_sticky", state, S_HALT);
        chk("halt_pulses", sum, 0);
        chk("halt_cnt", inst_cnt, 6);

        // counter wrap
        do_reset();
        idle(8);
        chk("wrap_run", state, S_RUN);
        for (int k = 0; k < 254; k++) begin
            tick = 1'b1; cyc();
            tick = 1'b0; cyc();
        end
        cyc();
        chk("wrap_fe", inst_cnt, 8'hFE);
        tick_pulse(p, f);
        chk("wrap_ff", inst_cnt, 8'hFF);
        tick_pulse(p, f);
        chk("wrap_00", inst_cnt, 8'h00);
        tick_pulse(p, f);
        chk("wrap_01", inst_cnt, 8'h01);

        // reset between tick edge and enable
        tick = 1'b1;
        #2;
        rst_n = 1'b0;
        #1;
        chk("async_state", state, S_PAUSE);
        chk("async_cnt", inst_cnt, 0);
        chk("async_en", cpu_en, 0);
        sum = 0;
        for (int i = 0; i < 3; i++) begin
            cyc();
            if (cpu_en) sum++;
        end
        tick = 1'b0;
        rst_n = 1'b1;
        for (int i = 0; i < 4; i++) begin
            cyc();
            if (cpu_en) sum++;
        end
        chk("async_no_en", sum, 0);
        chk("async_cnt_after", inst_cnt, 0);

        $display("test done: total=%0d bad=%0d", n_total, n_bad);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout: simulation did not finish, limit 200000 required less");
        $fatal(1);
    end

endmodule
